// File: rtl/neuron_lut_loader_if.sv
// Configuration stream and lookup bundle for one runtime-writable neuron LUT.
// The master side loads the table and issues lookups. The slave side is the loader.
interface neuron_lut_loader_if #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_last;
  logic                cfg_done;
  logic                cfg_err;
  logic                M0_valid;
  logic [IN_BITS-1:0]  M0;
  logic                M1_valid;
  logic [OUT_BITS-1:0] M1;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, M0_valid, M0,
    input  cfg_ready, cfg_done, cfg_err, M1_valid, M1
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_last, M0_valid, M0,
    output cfg_ready, cfg_done, cfg_err, M1_valid, M1
  );
endinterface

// File: rtl/neuron_lut_loader.sv
// Runtime-loadable neuron truth table: streamed in address order, then served as 1-cycle lookups.
// Define LUT_CFG_CHECK_EN to check cfg_last framing and report a sticky cfg_err.
module neuron_lut_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  neuron_lut_loader_if.slave  bus
);
  localparam int                 DEPTH    = 1 << IN_BITS;
  localparam logic [IN_BITS-1:0] ADDR_MAX = IN_BITS'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  waddr_q, waddr_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                cfg_done_q, cfg_done_d;
  logic                m1_valid_q, m1_valid_d;
  logic [OUT_BITS-1:0] m1_q, m1_d;

  logic                beat_acc;
  logic                wr_en;
  logic                last_addr;
  logic                frame_err;
  logic [OUT_BITS-1:0] rd_data;

  // Distributed-RAM table, never reset; only meaningful after a complete load.
  logic [OUT_BITS-1:0] table_mem [DEPTH];

  assign last_addr = (waddr_q == ADDR_MAX);
  assign beat_acc  = bus.cfg_valid && cfg_ready_q;
  assign rd_data   = table_mem[bus.M0];

`ifdef LUT_CFG_CHECK_EN
  logic err_q, err_d;

  assign frame_err = (bus.cfg_last != last_addr);

  always_comb begin
    err_d = err_q;
    if (bus.cfg_start) begin
      err_d = 1'b0;
    end else if (state_q == S_LOAD && beat_acc && frame_err) begin
      err_d = 1'b1;
    end
  end

  assign bus.cfg_err = err_q;
`else
  logic unused_cfg_last;

  assign unused_cfg_last = bus.cfg_last;
  assign frame_err       = 1'b0;
  assign bus.cfg_err     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    wr_en      = 1'b0;
    m1_valid_d = 1'b0;
    m1_d       = m1_q;

    // Lookups are gated on the state before this edge, so a request that
    // coincides with cfg_start in READY is still answered.
    if (state_q == S_READY && bus.M0_valid) begin
      m1_valid_d = 1'b1;
      m1_d       = rd_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          state_d = S_LOAD;
          waddr_d = '0;
        end
      end
      S_LOAD: begin
        if (bus.cfg_start) begin
          waddr_d = '0;
        end else if (beat_acc) begin
          wr_en = 1'b1;
          if (frame_err) begin
            state_d = S_IDLE;
            waddr_d = '0;
          end else if (last_addr) begin
            state_d = S_READY;
            waddr_d = '0;
          end else begin
            waddr_d = waddr_q + IN_BITS'(1);
          end
        end
      end
      S_READY: begin
        if (bus.cfg_start) begin
          state_d = S_LOAD;
          waddr_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        waddr_d = '0;
      end
    endcase

    cfg_ready_d = (state_d == S_LOAD);
    cfg_done_d  = (state_d == S_READY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      cfg_ready_q <= 1'b0;
      cfg_done_q  <= 1'b0;
      m1_valid_q  <= 1'b0;
      m1_q        <= '0;
`ifdef LUT_CFG_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_done_q  <= cfg_done_d;
      m1_valid_q  <= m1_valid_d;
      m1_q        <= m1_d;
`ifdef LUT_CFG_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      table_mem[waddr_q] <= bus.cfg_data;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.M1_valid  = m1_valid_q;
  assign bus.M1        = m1_q;
endmodule

// File: tb/tb_neuron_lut_loader.sv
// Self-checking bench for neuron_lut_loader: directed loads/lookups plus a
// randomized phase, all compared against a behavioural table model.
module tb_neuron_lut_loader;
  localparam int DEPTH = 256;
`ifdef LUT_CFG_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  neuron_lut_loader_if bus ();

  neuron_lut_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: which phase the loader is in, how many beats are in,
  // the table content and the last lookup answer.
  bit         m_loading, m_loaded, m_err, m_m1v;
  int         m_addr;
  logic [1:0] m_m1;
  logic [1:0] m_tab [DEPTH];

  logic [1:0] load_data [DEPTH];

  typedef struct {
    logic [7:0] addr;
    logic [1:0] exp;
  } vec_t;
  vec_t vecs [10];

  function automatic void chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  function automatic void chk2(string name, logic [1:0] act, logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  function automatic void model_edge(logic r, logic s, logic v, logic [1:0] d,
                                     logic l, logic mv, logic [7:0] a);
    if (r) begin
      m_loading = 0; m_loaded = 0; m_err = 0; m_m1v = 0; m_m1 = 2'b00; m_addr = 0;
    end else begin
      m_m1v = m_loaded && mv;
      if (m_loaded && mv) m_m1 = m_tab[a];
      if (s) begin
        m_loading = 1; m_loaded = 0; m_err = 0; m_addr = 0;
      end else if (m_loading && v) begin
        m_tab[m_addr] = d;
        if (CHK && (l != (m_addr == DEPTH - 1))) begin
          m_loading = 0; m_err = 1; m_addr = 0;
        end else if (m_addr == DEPTH - 1) begin
          m_loading = 0; m_loaded = 1; m_addr = 0;
        end else begin
          m_addr++;
        end
      end
    end
  endfunction

  task automatic step();
    logic r, s, v, l, mv;
    logic [1:0] d;
    logic [7:0] a;
    r = rst; s = bus.cfg_start; v = bus.cfg_valid; l = bus.cfg_last;
    d = bus.cfg_data; mv = bus.M0_valid; a = bus.M0;
    @(posedge clk);
    model_edge(r, s, v, d, l, mv, a);
    #1;
    chk1("cfg_ready", bus.cfg_ready, m_loading);
    chk1("cfg_done",  bus.cfg_done,  m_loaded);
    chk1("cfg_err",   bus.cfg_err,   m_err);
    chk1("M1_valid",  bus.M1_valid,  m_m1v);
    chk2("M1",        bus.M1,        m_m1);
  endtask

  task automatic clear_inputs();
    bus.cfg_start = 0; bus.cfg_valid = 0; bus.cfg_data = 2'b00; bus.cfg_last = 0;
    bus.M0_valid = 0; bus.M0 = 8'h00;
  endtask

  // Start pulse (with a decoy beat that must be discarded), then beats 0..stop_at-1.
  task automatic do_load(input bit gaps, input int stop_at, input int bad_last_at);
    bus.cfg_start = 1; bus.cfg_valid = 1; bus.cfg_data = 2'b10; bus.cfg_last = 1;
    bus.M0_valid = 1; bus.M0 = 8'($urandom);
    step();
    chk1("start_clears_err", bus.cfg_err, 1'b0);
    chk1("start_ready", bus.cfg_ready, 1'b1);
    chk1("start_not_done", bus.cfg_done, 1'b0);
    bus.cfg_start = 0;
    for (int i = 0; i < stop_at; i++) begin
      if (gaps) begin
        bus.cfg_valid = 0; bus.cfg_data = 2'($urandom); bus.M0 = 8'($urandom);
        step();
      end
      bus.cfg_valid = 1;
      bus.cfg_data  = load_data[i];
      bus.cfg_last  = (i == DEPTH - 1) || (i == bad_last_at);
      bus.M0 = 8'($urandom);
      step();
      chk1("load_no_lookup", bus.M1_valid, 1'b0);
    end
    clear_inputs();
    if (stop_at == DEPTH)
      chk1("load_done", bus.cfg_done, (bad_last_at < 0) || !CHK);
    else
      chk1("partial_ready", bus.cfg_ready, 1'b1);
    $display("load: beats=%0d gaps=%0d bad_last=%0d done=%b err=%b",
             stop_at, gaps, bad_last_at, bus.cfg_done, bus.cfg_err);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.M0_valid = 1; bus.M0 = 8'(a);
      step();
      chk1({tag, "_valid"}, bus.M1_valid, 1'b1);
      chk2({tag, "_data"}, bus.M1, load_data[a]);
    end
    clear_inputs();
    step();
    $display("sweep %s: 256 lookups done", tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] held;
    int r;
    vecs[0] = '{8'h23, 2'b01}; vecs[1] = '{8'h63, 2'b00};
    vecs[2] = '{8'h33, 2'b01}; vecs[3] = '{8'h37, 2'b01};
    vecs[4] = '{8'h3B, 2'b01}; vecs[5] = '{8'h3F, 2'b01};
    vecs[6] = '{8'h00, 2'b00}; vecs[7] = '{8'hFF, 2'b00};
    vecs[8] = '{8'h3E, 2'b00}; vecs[9] = '{8'h22, 2'b00};

    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    chk1("reset_ready", bus.cfg_ready, 1'b0);
    chk1("reset_done", bus.cfg_done, 1'b0);
    chk1("reset_err", bus.cfg_err, 1'b0);
    chk1("reset_m1v", bus.M1_valid, 1'b0);
    chk2("reset_m1", bus.M1, 2'b00);

    // Lookups and stray beats in IDLE are ignored.
    bus.M0_valid = 1; bus.M0 = 8'h23; bus.cfg_valid = 1;
    step();
    chk1("idle_no_lookup", bus.M1_valid, 1'b0);
    chk2("idle_m1_hold", bus.M1, 2'b00);
    clear_inputs();

    // Sparse table of 01 entries, table-driven lookups.
    for (int a = 0; a < DEPTH; a++)
      load_data[a] = (a == 'h23 || a == 'h33 || a == 'h37 || a == 'h3B || a == 'h3F) ? 2'b01 : 2'b00;
    do_load(0, DEPTH, -1);
    for (int i = 0; i < 10; i++) begin
      bus.M0_valid = 1; bus.M0 = vecs[i].addr;
      step();
      chk1("vec_valid", bus.M1_valid, 1'b1);
      chk2("vec_data", bus.M1, vecs[i].exp);
      $display("lookup M0=%h M1=%b", vecs[i].addr, bus.M1);
    end
    clear_inputs();
    step();
    chk1("vec_pulse_end", bus.M1_valid, 1'b0);

    // Throttled load, data = address low bits.
    for (int a = 0; a < DEPTH; a++) load_data[a] = 2'(a);
    do_load(1, DEPTH, -1);
    sweep("addr_bits");

    // Lookup coinciding with cfg_start is answered; later ones are not.
    held = 2'(8'h7E);
    bus.M0_valid = 1; bus.M0 = 8'h7E; bus.cfg_start = 1;
    step();
    chk1("start_edge_lookup", bus.M1_valid, 1'b1);
    chk2("start_edge_data", bus.M1, held);
    bus.cfg_start = 0; bus.M0 = 8'h01;
    step();
    chk1("load_blocks_lookup", bus.M1_valid, 1'b0);
    chk2("load_m1_hold", bus.M1, held);
    clear_inputs();

    // Restart at beat 100, then full reload with 11.
    do_load(0, 100, -1);
    for (int a = 0; a < DEPTH; a++) load_data[a] = 2'b11;
    do_load(0, DEPTH, -1);
    sweep("all_ones");

    // Reset at beat 200.
    for (int a = 0; a < DEPTH; a++) load_data[a] = 2'($urandom);
    do_load(0, 200, -1);
    bus.cfg_valid = 1; bus.cfg_data = load_data[200]; rst = 1;
    step();
    rst = 0;
    clear_inputs();
    chk1("rst_mid_ready", bus.cfg_ready, 1'b0);
    chk1("rst_mid_done", bus.cfg_done, 1'b0);
    bus.M0_valid = 1; bus.cfg_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.M0 = 8'(i * 37);
      step();
      chk1("rst_no_lookup", bus.M1_valid, 1'b0);
    end
    clear_inputs();
    do_load(0, DEPTH, -1);
    sweep("after_rst");

    // Misplaced cfg_last on beat 10.
    for (int a = 0; a < DEPTH; a++) load_data[a] = 2'($urandom);
    do_load(0, DEPTH, 10);
    chk1("bad_last_err", bus.cfg_err, CHK);
    chk1("bad_last_done", bus.cfg_done, !CHK);
    chk1("bad_last_ready", bus.cfg_ready, 1'b0);
    do_load(0, DEPTH, -1);
    chk1("reload_err", bus.cfg_err, 1'b0);
    sweep("reload");

    // Randomized phase against the model.
    for (int c = 0; c < 5000; c++) begin
      r = int'($urandom_range(999));
      bus.cfg_start = (!m_loading && !m_loaded && r < 20) || (m_loaded && r < 8) || (m_loading && r == 999);
      bus.cfg_valid = ($urandom_range(9) < 7);
      bus.cfg_data  = 2'($urandom);
      bus.cfg_last  = (m_addr == DEPTH - 1);
      if ($urandom_range(1999) == 0) bus.cfg_last = ~bus.cfg_last;
      bus.M0_valid  = 1'($urandom_range(1));
      bus.M0        = 8'($urandom);
      rst           = ($urandom_range(2999) == 0);
      step();
    end
    rst = 0;
    clear_inputs();
    step();
    $display("random: 5000 cycles done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
